// File: rtl/pic_pkg.sv
// ============================================================================
// Module      : pic_pkg
// Description : Shared widths, vector constants, FSM state and flow-op select
//               encodings for the PIC-style program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pic_pkg;

  localparam int PC_W     = 13;
  localparam int PCLATH_W = 5;
  localparam int LIT_W    = 11;
  localparam int PCL_W    = 8;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 13'h0000;
  localparam logic [PC_W-1:0] INT_VECTOR_DEF   = 13'h0004;

  typedef enum logic [0:0] {
    ST_EXEC  = 1'b0,
    ST_FLUSH = 1'b1
  } seq_state_e;

  typedef enum logic [2:0] {
    SEL_INC    = 3'd0,
    SEL_CALL   = 3'd1,
    SEL_GOTO   = 3'd2,
    SEL_RETURN = 3'd3,
    SEL_RETFIE = 3'd4,
    SEL_PCL    = 3'd5,
    SEL_SKIP   = 3'd6,
    SEL_INT    = 3'd7
  } flow_sel_e;

  // Fixed-priority resolution of the flow op for an EXEC cycle.
  // int_ok must already be qualified by the global interrupt enable.
  function automatic flow_sel_e flow_select(
    input logic call,
    input logic go_to,
    input logic ret,
    input logic retfie,
    input logic pcl_wr,
    input logic skip,
    input logic int_ok
  );
    flow_sel_e sel;
    sel = SEL_INC;
    if (call)        sel = SEL_CALL;
    else if (go_to)  sel = SEL_GOTO;
    else if (ret)    sel = SEL_RETURN;
    else if (retfie) sel = SEL_RETFIE;
    else if (pcl_wr) sel = SEL_PCL;
    else if (skip)   sel = SEL_SKIP;
    else if (int_ok) sel = SEL_INT;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/call_stack.sv
// ============================================================================
// Module      : call_stack
// Description : Circular hardware return stack. Push on full overwrites the
//               oldest entry; pop on empty wraps the pointer and returns
//               stale data. Contents are never reset, only the pointer.
// Ports       : clk, rst (async, active-high), push, pop, data_in, data_out
//               (top of stack, combinational), and when PC_SEQ_STACK_FLAGS_EN
//               is defined: stk_ovf, stk_unf (sticky, cleared by rst only).
// Config      : `PC_SEQ_STACK_FLAGS_EN adds the occupancy counter and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module call_stack
  import pic_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int WIDTH       = PC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef PC_SEQ_STACK_FLAGS_EN
  ,
  output logic             stk_ovf,
  output logic             stk_unf
`endif
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_dec;

  // ptr addresses the next free slot; the top entry sits one below it.
  assign ptr_dec  = ptr - PTR_W'(1);
  assign data_out = mem[ptr_dec];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
    end else if (pop) begin
      ptr <= ptr_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= data_in;
    end
  end

`ifdef PC_SEQ_STACK_FLAGS_EN
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [CNT_W-1:0] occupancy;

  // Occupancy saturates at both ends; the pointer keeps wrapping regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
    end else if (push) begin
      if (occupancy == CNT_W'(STACK_DEPTH)) begin
        stk_ovf <= 1'b1;
      end else begin
        occupancy <= occupancy + CNT_W'(1);
      end
    end else if (pop) begin
      if (occupancy == '0) begin
        stk_unf <= 1'b1;
      end else begin
        occupancy <= occupancy - CNT_W'(1);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter, PCLATH and two-state fetch FSM for a
//               PIC-style core. Any taken change of flow moves to FLUSH so the
//               already-fetched instruction is replaced by a NOP.
// Ports       : clk, rst (async, active-high), cycle_en, op_goto, op_call,
//               op_return, op_retfie, lit_in[10:0], skip_taken, pcl_wr_en,
//               pcl_in[7:0], pclath_wr_en, pclath_in[4:0], int_req, gie,
//               pc_out[12:0], pclath_out[4:0], flush, gie_clr, gie_set,
//               and stk_ovf/stk_unf when PC_SEQ_STACK_FLAGS_EN is defined.
// Config      : `PC_SEQ_STACK_FLAGS_EN exposes sticky stack flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pic_pkg::*;
#(
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [PC_W-1:0] INT_VECTOR   = INT_VECTOR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cycle_en,
  input  logic                op_goto,
  input  logic                op_call,
  input  logic                op_return,
  input  logic                op_retfie,
  input  logic [LIT_W-1:0]    lit_in,
  input  logic                skip_taken,
  input  logic                pcl_wr_en,
  input  logic [PCL_W-1:0]    pcl_in,
  input  logic                pclath_wr_en,
  input  logic [PCLATH_W-1:0] pclath_in,
  input  logic                int_req,
  input  logic                gie,
  output logic [PC_W-1:0]     pc_out,
  output logic [PCLATH_W-1:0] pclath_out,
  output logic                flush,
  output logic                gie_clr,
  output logic                gie_set
`ifdef PC_SEQ_STACK_FLAGS_EN
  ,
  output logic                stk_ovf,
  output logic                stk_unf
`endif
);

  seq_state_e          state;
  seq_state_e          state_next;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_next;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     jump_target;
  logic [PC_W-1:0]     pcl_target;
  logic [PC_W-1:0]     stack_top;
  logic [PCLATH_W-1:0] pclath;
  logic                push;
  logic                pop;
  flow_sel_e           sel;

  // Targets use the registered PCLATH, so a same-cycle PCLATH write only
  // affects later jumps.
  assign pc_inc      = pc + PC_W'(1);
  assign jump_target = {pclath[PCLATH_W-1:PCLATH_W-2], lit_in};
  assign pcl_target  = {pclath, pcl_in};

  assign sel = flow_select(op_call, op_goto, op_return, op_retfie,
                           pcl_wr_en, skip_taken, int_req & gie);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    pop        = 1'b0;
    gie_clr    = 1'b0;
    gie_set    = 1'b0;
    if (cycle_en) begin
      if (state == ST_FLUSH) begin
        pc_next    = pc_inc;
        state_next = ST_EXEC;
      end else begin
        state_next = ST_FLUSH;
        case (sel)
          SEL_CALL: begin
            push    = 1'b1;
            pc_next = jump_target;
          end
          SEL_GOTO: begin
            pc_next = jump_target;
          end
          SEL_RETURN: begin
            pop     = 1'b1;
            pc_next = stack_top;
          end
          SEL_RETFIE: begin
            pop     = 1'b1;
            pc_next = stack_top;
            gie_set = 1'b1;
          end
          SEL_PCL: begin
            pc_next = pcl_target;
          end
          SEL_SKIP: begin
            pc_next = pc_inc;
          end
          SEL_INT: begin
            push    = 1'b1;
            pc_next = INT_VECTOR;
            gie_clr = 1'b1;
          end
          SEL_INC: begin
            pc_next    = pc_inc;
            state_next = ST_EXEC;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EXEC;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // PCLATH is a plain register write port, independent of cycle_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclath <= '0;
    end else if (pclath_wr_en) begin
      pclath <= pclath_in;
    end
  end

  call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .WIDTH       (PC_W)
  ) u_call_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (pc),
    .data_out (stack_top)
`ifdef PC_SEQ_STACK_FLAGS_EN
    ,
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
`endif
  );

  assign pc_out     = pc;
  assign pclath_out = pclath;
  assign flush      = (state == ST_FLUSH);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A behavioural model
//               predicts each cycle's outputs, pushes them to a scoreboard
//               queue as stimulus is driven, and the entry is popped and
//               compared once the DUT has taken the clock edge.
// Config      : honours `PC_SEQ_STACK_FLAGS_EN for the optional flag ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pc_sequencer;
  import pic_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cycle_en = 1'b0;
  logic        op_goto = 1'b0, op_call = 1'b0, op_return = 1'b0, op_retfie = 1'b0;
  logic [10:0] lit_in = '0;
  logic        skip_taken = 1'b0;
  logic        pcl_wr_en = 1'b0;
  logic [7:0]  pcl_in = '0;
  logic        pclath_wr_en = 1'b0;
  logic [4:0]  pclath_in = '0;
  logic        int_req = 1'b0, gie = 1'b0;
  logic [12:0] pc_out;
  logic [4:0]  pclath_out;
  logic        flush, gie_clr, gie_set;
  logic        stk_ovf, stk_unf;

  always #5 clk = ~clk;

  pc_sequencer #(
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (13'h0000),
    .INT_VECTOR   (13'h0004)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cycle_en     (cycle_en),
    .op_goto      (op_goto),
    .op_call      (op_call),
    .op_return    (op_return),
    .op_retfie    (op_retfie),
    .lit_in       (lit_in),
    .skip_taken   (skip_taken),
    .pcl_wr_en    (pcl_wr_en),
    .pcl_in       (pcl_in),
    .pclath_wr_en (pclath_wr_en),
    .pclath_in    (pclath_in),
    .int_req      (int_req),
    .gie          (gie),
    .pc_out       (pc_out),
    .pclath_out   (pclath_out),
    .flush        (flush),
    .gie_clr      (gie_clr),
    .gie_set      (gie_set)
`ifdef PC_SEQ_STACK_FLAGS_EN
    ,
    .stk_ovf      (stk_ovf),
    .stk_unf      (stk_unf)
`endif
  );

`ifndef PC_SEQ_STACK_FLAGS_EN
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

  typedef struct {
    logic [12:0] pc;
    logic        fl;
    logic [4:0]  pclath;
    logic        clr;
    logic        set;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [12:0] m_pc;
  logic        m_flush;
  logic [4:0]  m_pclath;
  logic [12:0] m_stack [DEPTH];
  logic [2:0]  m_sp;
  int          m_cnt;
  logic        m_ovf, m_unf;

  logic        obs_clr, obs_set;
  logic [12:0] call9_ret;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 13'h0000; m_flush = 1'b0; m_pclath = 5'h00;
    m_sp = '0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic m_push(input logic [12:0] v);
    if (m_cnt == DEPTH) m_ovf = 1'b1;
    else m_cnt++;
    m_stack[m_sp] = v;
    m_sp = m_sp + 3'd1;
  endtask

  task automatic m_pop(output logic [12:0] v);
    if (m_cnt == 0) m_unf = 1'b1;
    else m_cnt--;
    m_sp = m_sp - 3'd1;
    v = m_stack[m_sp];
  endtask

  task automatic clear_ins();
    cycle_en = 1'b1;
    op_goto = 1'b0; op_call = 1'b0; op_return = 1'b0; op_retfie = 1'b0;
    lit_in = '0; skip_taken = 1'b0; pcl_wr_en = 1'b0; pcl_in = '0;
    pclath_wr_en = 1'b0; pclath_in = '0; int_req = 1'b0; gie = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at posedge+1.
  task automatic step();
    exp_t        e;
    exp_t        got;
    logic [12:0] npc;
    logic        nfl;
    e.clr = 1'b0; e.set = 1'b0;
    npc = m_pc; nfl = m_flush;
    if (cycle_en) begin
      nfl = 1'b1;
      if (m_flush) begin
        npc = m_pc + 13'd1; nfl = 1'b0;
      end else if (op_call) begin
        m_push(m_pc); npc = {m_pclath[4:3], lit_in};
      end else if (op_goto) begin
        npc = {m_pclath[4:3], lit_in};
      end else if (op_return) begin
        m_pop(npc);
      end else if (op_retfie) begin
        m_pop(npc); e.set = 1'b1;
      end else if (pcl_wr_en) begin
        npc = {m_pclath, pcl_in};
      end else if (skip_taken) begin
        npc = m_pc + 13'd1;
      end else if (int_req && gie) begin
        m_push(m_pc); npc = 13'h0004; e.clr = 1'b1;
      end else begin
        npc = m_pc + 13'd1; nfl = 1'b0;
      end
    end
    if (pclath_wr_en) m_pclath = pclath_in;
    m_pc = npc; m_flush = nfl;
    e.pc = m_pc; e.fl = m_flush; e.pclath = m_pclath;
    e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);

    @(negedge clk);
    obs_clr = gie_clr;
    obs_set = gie_set;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check_eq("pc_out", {19'd0, pc_out}, {19'd0, got.pc});
      check_eq("flush", {31'd0, flush}, {31'd0, got.fl});
      check_eq("pclath_out", {27'd0, pclath_out}, {27'd0, got.pclath});
      check_eq("gie_clr", {31'd0, obs_clr}, {31'd0, got.clr});
      check_eq("gie_set", {31'd0, obs_set}, {31'd0, got.set});
`ifdef PC_SEQ_STACK_FLAGS_EN
      check_eq("stk_ovf", {31'd0, stk_ovf}, {31'd0, got.ovf});
      check_eq("stk_unf", {31'd0, stk_unf}, {31'd0, got.unf});
`endif
    end
    clear_ins();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ins();
    cycle_en = 1'b0;
    rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    check_eq("rst_pc", {19'd0, pc_out}, 32'h0);
    check_eq("rst_flush", {31'd0, flush}, 32'h0);
    check_eq("rst_pclath", {27'd0, pclath_out}, 32'h0);
    check_eq("rst_gie_clr", {31'd0, gie_clr}, 32'h0);
    check_eq("rst_gie_set", {31'd0, gie_set}, 32'h0);
    clear_ins();

    // Plain increments 0 -> 1 -> 2 -> 3 -> 4
    repeat (4) step();
    // PCLATH write on an increment cycle, pc 4 -> 5
    pclath_wr_en = 1'b1; pclath_in = 5'h18; step();
    // GOTO at pc 5 -> 0x1923, then flush -> 0x1924
    op_goto = 1'b1; lit_in = 11'h123; step();
    step();

    // cycle_en low: everything holds, no pulses
    cycle_en = 1'b0; op_call = 1'b1; lit_in = 11'h7FF; int_req = 1'b1; gie = 1'b1; step();

    // Same-cycle PCLATH write: target uses the old PCLATH (0x18)
    op_goto = 1'b1; lit_in = 11'h055; pclath_wr_en = 1'b1; pclath_in = 5'h02; step();
    // Flow inputs and interrupts ignored while flushing
    op_goto = 1'b1; lit_in = 11'h3AB; int_req = 1'b1; gie = 1'b1; step();

    // PCL write -> {0x02, 0x34}
    pcl_wr_en = 1'b1; pcl_in = 8'h34; step();
    step();
    skip_taken = 1'b1; step();
    step();
    // Interrupt pending but disabled
    int_req = 1'b1; gie = 1'b0; step();

    // 13-bit wrap: 0x1FFF + 1 = 0x0000
    pclath_wr_en = 1'b1; pclath_in = 5'h1F; step();
    pcl_wr_en = 1'b1; pcl_in = 8'hFF; step();
    step();

    // Interrupt entry at pc 0x40, later RETFIE back to it
    pclath_wr_en = 1'b1; pclath_in = 5'h00; step();
    pcl_wr_en = 1'b1; pcl_in = 8'h3F; step();
    step();
    int_req = 1'b1; gie = 1'b1; step();
    repeat (3) step();
    op_retfie = 1'b1; step();
    step();

    // CALL wins over interrupt; interrupt taken on first EXEC after FLUSH
    op_call = 1'b1; lit_in = 11'h200; int_req = 1'b1; gie = 1'b1; step();
    int_req = 1'b1; gie = 1'b1; step();
    int_req = 1'b1; gie = 1'b1; step();
    step();

    // Asynchronous reset while in FLUSH
    op_goto = 1'b1; lit_in = 11'h0AA; step();
    cycle_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_pc", {19'd0, pc_out}, 32'h0);
    check_eq("async_rst_flush", {31'd0, flush}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    check_eq("post_rst_pc", {19'd0, pc_out}, 32'h0);
    check_eq("post_rst_flush", {31'd0, flush}, 32'h0);
    clear_ins();

    // Nine nested CALLs (one wraps), then nine RETURNs (one underflows)
    for (int i = 0; i < 9; i++) begin
      if (i == 8) call9_ret = m_pc;
      op_call = 1'b1; lit_in = 11'h100 + 11'(i * 8); step();
      step();
    end
    for (int i = 0; i < 9; i++) begin
      op_return = 1'b1; step();
      step();
    end
    // After the trailing flush step pc has advanced by one past the return target
    check_eq("ret9_wrapped", {19'd0, pc_out}, {19'd0, call9_ret + 13'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 8, number of return-stack entries; the value SHALL be a power of two.
REQ-002 Parameter RESET_VECTOR, default 13'h0000, PC value loaded at reset.
REQ-003 Parameter INT_VECTOR, default 13'h0004, PC value loaded on interrupt entry.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cycle_en  in  1  instruction-cycle strobe; state SHALL advance only when 1.
REQ-007 op_goto, op_call, op_return, op_retfie  in  1 each  decoded flow ops of the executing instruction; RETLW drives op_return.
REQ-008 lit_in  in  11  GOTO/CALL literal.
REQ-009 skip_taken  in  1  conditional skip resolved true.
REQ-010 pcl_wr_en  in  1  PCL write; pcl_in  in  8  write data.
REQ-011 pclath_wr_en  in  1  PCLATH write; pclath_in  in  5  write data.
REQ-012 int_req  in  1  interrupt pending; gie  in  1  global interrupt enable.
REQ-013 pc_out  out  13  fetch address; pclath_out  out  5  PCLATH register.
REQ-014 flush  out  1  forces a NOP into the instruction register for the current cycle.
REQ-015 gie_clr, gie_set  out  1 each  single-cycle pulses, qualified by cycle_en.

Function
REQ-016 FSM states: EXEC and FLUSH; flush SHALL be 1 exactly when state is FLUSH.
REQ-017 In EXEC with cycle_en=1, the flow op SHALL be chosen by priority op_call > op_goto > op_return > op_retfie > pcl_wr_en > skip_taken > interrupt > increment.
REQ-018 CALL: push pc_out; pc <= {pclath[4:3], lit_in}; go to FLUSH.
REQ-019 GOTO: pc <= {pclath[4:3], lit_in}; go to FLUSH.
REQ-020 RETURN: pc <= pop; go to FLUSH. RETFIE: identical, plus gie_set=1.
REQ-021 PCL write: pc <= {pclath, pcl_in}; go to FLUSH.
REQ-022 Skip: pc <= pc+1; go to FLUSH.
REQ-023 Interrupt: taken only when int_req & gie and no higher-priority op; push pc_out; pc <= INT_VECTOR; gie_clr=1; go to FLUSH.
REQ-024 Otherwise pc <= pc+1 and the FSM SHALL stay in EXEC.
REQ-025 FLUSH with cycle_en=1: pc <= pc+1, go to EXEC; all flow inputs and interrupts SHALL be ignored.
REQ-026 PC arithmetic is 13-bit modulo; 13'h1FFF+1 SHALL give 13'h0000.
REQ-027 pclath_wr_en SHALL update PCLATH in any state; a target computed in the same cycle SHALL use the old PCLATH.
REQ-028 Stack: circular, STACK_DEPTH x 13 bits, log2(STACK_DEPTH)-bit pointer.
REQ-029 Push on full SHALL overwrite the oldest entry (wrap); pop on empty SHALL wrap the pointer and return stale data; neither SHALL raise an error.
REQ-030 With cycle_en=0, pc, state, stack and PCLATH SHALL hold (except REQ-027) and pulse outputs SHALL be 0.

Reset
REQ-031 On rst: pc=RESET_VECTOR, pclath=0, state=EXEC, stack pointer=0, flush=0, gie_clr=0, gie_set=0; stack contents are not reset.
REQ-032 rst asserted mid-FLUSH or mid-push SHALL take effect immediately; the first EXEC after release SHALL fetch RESET_VECTOR.

Configuration
REQ-033 Macro PC_SEQ_STACK_FLAGS_EN defined: add outputs stk_ovf and stk_unf (1 bit each, sticky, cleared only by rst), set on a push at depth STACK_DEPTH and a pop at depth 0; an occupancy counter 0..STACK_DEPTH SHALL track depth; wrap behaviour is unchanged.
REQ-034 Macro undefined: no flag ports and no occupancy counter.

Structure
REQ-035 Shared package pic_pkg: PC width (13), PCLATH width (5), the vector constants, and the flow-op select enum.
REQ-036 Sub-module call_stack (push, pop, data_in, data_out, optional flags) SHALL hold the stack; the FSM and PC register SHALL live in pc_sequencer.

Verification
REQ-037 Reset release, cycle_en=1 for 3 cycles -> pc_out 0,1,2,3; flush=0.
REQ-038 pclath=5'h18, GOTO lit=11'h123 at pc=5 -> pc_out 13'h1923, flush=1 for one cycle, then 13'h1924.
REQ-039 Nine nested CALLs, then nine RETURNs -> the 9th return yields the 1st-overwritten (wrapped) address; with the macro, stk_ovf=1 after the 9th call and stk_unf=1 after the 9th return.
REQ-040 int_req=gie=1 at pc=13'h0040 with no op -> push 13'h0040, pc 13'h0004, gie_clr pulse, flush; a later RETFIE -> pc 13'h0040, gie_set pulse.
REQ-041 op_call and int_req in the same cycle -> CALL executes; interrupt is taken in the first EXEC after FLUSH.
REQ-042 rst asserted during FLUSH -> pc_out 0 and flush 0 asynchronously, before the next clk edge.
